// File: rtl/pn_shift_ctrl_gen_pkg.sv
// Shared constants, shift type and modulo-Z helpers for the Z=96 permutation network.
package pn_pkg;
  localparam int unsigned Z  = 96;
  localparam int unsigned SW = 7;

  typedef logic [SW-1:0] shift_t;

  localparam shift_t Z_S = shift_t'(Z);

  // Inputs never exceed 127 < 2Z, so one conditional subtraction reduces fully.
  function automatic shift_t mod_z(input shift_t s);
    return (s >= Z_S) ? shift_t'(s - Z_S) : s;
  endfunction

  function automatic shift_t inv_shift(input shift_t s);
    return (s == '0) ? '0 : shift_t'(Z_S - s);
  endfunction
endpackage

// File: rtl/pn_shift_ctrl_gen_fifo.sv
// Synchronous FIFO of accepted shifts awaiting their inverse permutation.
module pn_shift_fifo
  import pn_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          push,
  input  logic [SW-1:0] wdata,
  input  logic          pop,
  output logic [SW-1:0] rdata,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);
  shift_t        mem [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign rdata = mem[rptr_q];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (clr) begin
      wptr_d = '0;
      rptr_d = '0;
      cnt_d  = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clr) mem[wptr_q] <= wdata;
  end
endmodule

// File: rtl/pn_shift_ctrl_gen.sv
// Forward/inverse permutation-network control word generator for the Z=96 LDPC decoder.
// Define PN_STATUS_EN to add the err_range, err_underflow and fifo_count status ports.
module pn_shift_ctrl_gen
  import pn_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [SW-1:0] shift_in,
  input  logic          shift_valid,
  output logic          shift_ready,
  output logic [SW-1:0] fwd_ctrl,
  output logic          fwd_valid,
  input  logic          inv_req,
  output logic [SW-1:0] inv_ctrl,
  output logic          inv_valid
`ifdef PN_STATUS_EN
  ,
  output logic          err_range,
  output logic          err_underflow,
  output logic [SW-1:0] fifo_count
`endif
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [CW-1:0] cnt;
  logic          full, empty, accept, pop;
  shift_t        s_mod, rdata;
  shift_t        fwd_ctrl_q, fwd_ctrl_d, inv_ctrl_q, inv_ctrl_d;
  logic          fwd_valid_q, fwd_valid_d, inv_valid_q, inv_valid_d;

  assign shift_ready = (cnt != CW'(DEPTH));
  // full mirrors !shift_ready; a same-cycle pop never opens a slot for a push.
  assign accept      = shift_valid && !full && !clr;
  assign pop         = inv_req && !empty && !clr;
  assign s_mod       = mod_z(shift_in);

  pn_shift_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (accept),
    .wdata (s_mod),
    .pop   (pop),
    .rdata (rdata),
    .full  (full),
    .empty (empty),
    .count (cnt)
  );

  always_comb begin
    fwd_valid_d = accept;
    fwd_ctrl_d  = accept ? s_mod : fwd_ctrl_q;
    inv_valid_d = pop;
    inv_ctrl_d  = pop ? inv_shift(rdata) : inv_ctrl_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_ctrl_q  <= '0;
      fwd_valid_q <= 1'b0;
      inv_ctrl_q  <= '0;
      inv_valid_q <= 1'b0;
    end else begin
      fwd_ctrl_q  <= fwd_ctrl_d;
      fwd_valid_q <= fwd_valid_d;
      inv_ctrl_q  <= inv_ctrl_d;
      inv_valid_q <= inv_valid_d;
    end
  end

  assign fwd_ctrl  = fwd_ctrl_q;
  assign fwd_valid = fwd_valid_q;
  assign inv_ctrl  = inv_ctrl_q;
  assign inv_valid = inv_valid_q;

`ifdef PN_STATUS_EN
  logic err_range_q, err_range_d, err_underflow_q, err_underflow_d;

  always_comb begin
    err_range_d     = err_range_q;
    err_underflow_d = err_underflow_q;
    if (clr) begin
      err_range_d     = 1'b0;
      err_underflow_d = 1'b0;
    end else begin
      if (accept && (shift_in >= Z_S)) err_range_d = 1'b1;
      if (inv_req && empty)            err_underflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_range_q     <= 1'b0;
      err_underflow_q <= 1'b0;
    end else begin
      err_range_q     <= err_range_d;
      err_underflow_q <= err_underflow_d;
    end
  end

  assign err_range     = err_range_q;
  assign err_underflow = err_underflow_q;
  assign fifo_count    = SW'(cnt);
`endif
endmodule

// File: tb/tb_pn_shift_ctrl_gen.sv
// Directed, table-driven bench for pn_shift_ctrl_gen (status checks active with PN_STATUS_EN).
module tb_pn_shift_ctrl_gen;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clr = 1'b0;
  logic [6:0] shift_in = '0;
  logic       shift_valid = 1'b0;
  logic       shift_ready;
  logic [6:0] fwd_ctrl;
  logic       fwd_valid;
  logic       inv_req = 1'b0;
  logic [6:0] inv_ctrl;
  logic       inv_valid;
`ifdef PN_STATUS_EN
  logic       err_range;
  logic       err_underflow;
  logic [6:0] fifo_count;
`endif

  int unsigned tests = 0;
  int unsigned fails = 0;

  always #5 clk = ~clk;

  pn_shift_ctrl_gen #(.DEPTH(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (clr),
    .shift_in     (shift_in),
    .shift_valid  (shift_valid),
    .shift_ready  (shift_ready),
    .fwd_ctrl     (fwd_ctrl),
    .fwd_valid    (fwd_valid),
    .inv_req      (inv_req),
    .inv_ctrl     (inv_ctrl),
    .inv_valid    (inv_valid)
`ifdef PN_STATUS_EN
    ,
    .err_range    (err_range),
    .err_underflow(err_underflow),
    .fifo_count   (fifo_count)
`endif
  );

  typedef struct {
    logic [6:0] sh;
    logic [6:0] fwd;
    logic [6:0] inv;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [6:0] exp_q [$];
  logic       exp_rng;

  initial begin
    vecs[0] = '{7'd5,   7'd5,  7'd91};
    vecs[1] = '{7'd0,   7'd0,  7'd0};
    vecs[2] = '{7'd1,   7'd1,  7'd95};
    vecs[3] = '{7'd95,  7'd95, 7'd1};
    vecs[4] = '{7'd48,  7'd48, 7'd48};
    vecs[5] = '{7'd47,  7'd47, 7'd49};
    vecs[6] = '{7'd100, 7'd4,  7'd92};
    vecs[7] = '{7'd127, 7'd31, 7'd65};
    vecs[8] = '{7'd96,  7'd0,  7'd0};
    exp_rng = 1'b0;

    step(); step();
    chk("reset_fwd_valid", fwd_valid, 0);
    chk("reset_fwd_ctrl", fwd_ctrl, 0);
    chk("reset_inv_valid", inv_valid, 0);
    chk("reset_inv_ctrl", inv_ctrl, 0);
    rst_n = 1'b1;
    step();
    chk("reset_ready", shift_ready, 1);
`ifdef PN_STATUS_EN
    chk("reset_count", fifo_count, 0);
    chk("reset_err_range", err_range, 0);
`endif

    // Single push then single pop per vector.
    for (int i = 0; i < 9; i++) begin
      shift_in = vecs[i].sh; shift_valid = 1'b1;
      step();
      shift_valid = 1'b0;
      if (vecs[i].sh >= 7'd96) exp_rng = 1'b1;
      chk($sformatf("vec%0d_fwd_valid", i), fwd_valid, 1);
      chk($sformatf("vec%0d_fwd_ctrl", i), fwd_ctrl, vecs[i].fwd);
`ifdef PN_STATUS_EN
      chk($sformatf("vec%0d_err_range", i), err_range, exp_rng);
`endif
      inv_req = 1'b1;
      step();
      inv_req = 1'b0;
      chk($sformatf("vec%0d_fwd_drop", i), fwd_valid, 0);
      chk($sformatf("vec%0d_fwd_hold", i), fwd_ctrl, vecs[i].fwd);
      chk($sformatf("vec%0d_inv_valid", i), inv_valid, 1);
      chk($sformatf("vec%0d_inv_ctrl", i), inv_ctrl, vecs[i].inv);
    end
    step();
    chk("idle_inv_valid", inv_valid, 0);

    // Back-to-back pushes 0,1,95,48 then four pops.
    exp_q = '{7'd0, 7'd95, 7'd1, 7'd48};
    for (int i = 0; i < 4; i++) begin
      shift_in = (i == 0) ? 7'd0 : (i == 1) ? 7'd1 : (i == 2) ? 7'd95 : 7'd48;
      shift_valid = 1'b1;
      step();
      chk($sformatf("b2b%0d_fwd_valid", i), fwd_valid, 1);
      chk($sformatf("b2b%0d_fwd_ctrl", i), fwd_ctrl, shift_in);
    end
    shift_valid = 1'b0;
    inv_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("b2b%0d_inv_valid", i), inv_valid, 1);
      chk($sformatf("b2b%0d_inv_ctrl", i), inv_ctrl, exp_q[i]);
      chk($sformatf("b2b%0d_ready", i), shift_ready, 1);
    end
    inv_req = 1'b0;
    step();
    chk("b2b_empty_inv_valid", inv_valid, 0);

    // Fill to DEPTH, stall, then pop+valid in the same cycle.
    shift_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      shift_in = 7'(10 + i);
      chk($sformatf("fill%0d_ready", i), shift_ready, 1);
      step();
    end
    chk("full_ready", shift_ready, 0);
`ifdef PN_STATUS_EN
    chk("full_count", fifo_count, 8);
`endif
    shift_in = 7'd50;
    step();
    chk("stall_fwd_valid", fwd_valid, 0);
    inv_req = 1'b1;
    step();
    inv_req = 1'b0;
    chk("fullpop_inv_valid", inv_valid, 1);
    chk("fullpop_inv_ctrl", inv_ctrl, 86);
    chk("fullpop_no_push", fwd_valid, 0);
    chk("fullpop_ready", shift_ready, 1);
    step();
    shift_valid = 1'b0;
    chk("latepush_fwd_valid", fwd_valid, 1);
    chk("latepush_fwd_ctrl", fwd_ctrl, 50);
    chk("latepush_ready", shift_ready, 0);
`ifdef PN_STATUS_EN
    chk("latepush_count", fifo_count, 8);
`endif
    inv_req = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("drain%0d_inv_valid", i), inv_valid, 1);
      chk($sformatf("drain%0d_inv_ctrl", i), inv_ctrl, (i == 7) ? 46 : 85 - i);
    end
    // Ninth request finds the FIFO empty.
    step();
    inv_req = 1'b0;
    chk("underflow_inv_valid", inv_valid, 0);
`ifdef PN_STATUS_EN
    chk("underflow_flag", err_underflow, 1);
    chk("underflow_range_sticky", err_range, 1);
`endif
    clr = 1'b1;
    step();
    clr = 1'b0;
`ifdef PN_STATUS_EN
    chk("clr_underflow", err_underflow, 0);
    chk("clr_range", err_range, 0);
    chk("clr_count", fifo_count, 0);
`endif
    chk("clr_ready", shift_ready, 1);

    // Same-cycle push and pop with a non-empty FIFO.
    shift_in = 7'd20; shift_valid = 1'b1;
    step();
    shift_in = 7'd30; inv_req = 1'b1;
    step();
    shift_valid = 1'b0;
    chk("pp_inv_valid", inv_valid, 1);
    chk("pp_inv_ctrl", inv_ctrl, 76);
    chk("pp_fwd_ctrl", fwd_ctrl, 30);
    step();
    inv_req = 1'b0;
    chk("pp2_inv_ctrl", inv_ctrl, 66);
    chk("pp2_fwd_valid", fwd_valid, 0);

    // clr discards same-cycle accept and pop.
    shift_in = 7'd7; shift_valid = 1'b1;
    step();
    shift_in = 7'd9; inv_req = 1'b1; clr = 1'b1;
    step();
    clr = 1'b0; shift_valid = 1'b0;
    chk("clrcyc_fwd_valid", fwd_valid, 0);
    chk("clrcyc_inv_valid", inv_valid, 0);
    chk("clrcyc_fwd_hold", fwd_ctrl, 7);
    step();
    inv_req = 1'b0;
    chk("clrcyc_flushed", inv_valid, 0);

    // Reset mid-stream.
    shift_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      shift_in = 7'(60 + i);
      step();
    end
    shift_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_fwd_valid", fwd_valid, 0);
    chk("rst_async_fwd_ctrl", fwd_ctrl, 0);
    step();
    rst_n = 1'b1;
    step();
    chk("rst_ready", shift_ready, 1);
`ifdef PN_STATUS_EN
    chk("rst_count", fifo_count, 0);
`endif
    inv_req = 1'b1;
    step();
    inv_req = 1'b0;
    chk("rst_no_inv", inv_valid, 0);
    chk("rst_no_fwd", fwd_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
